// File: rtl/abr_params_pkg.sv
// Shared memory-interface types and widths for the decoder/memory fabric.
package abr_params_pkg;

    localparam int ABR_MEM_ADDR_WIDTH = 15;
    localparam int ABR_MEM_LANES      = 4;
    localparam int ABR_MEM_LANE_WIDTH = 24;

    typedef enum logic [1:0] {
        RW_IDLE  = 2'b00,
        RW_READ  = 2'b01,
        RW_WRITE = 2'b10
    } mem_rw_mode_e;

    typedef struct packed {
        mem_rw_mode_e                  rd_wr_en;
        logic [ABR_MEM_ADDR_WIDTH-1:0] addr;
    } mem_if_t;

    typedef logic [ABR_MEM_LANES-1:0][ABR_MEM_LANE_WIDTH-1:0] mem_data_t;

endpackage

// File: rtl/abr_rr_arbiter.sv
// Round-robin pick: the first pending requester after i_last wins (one-hot out).
module abr_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [N-1:0]     o_grant
);

    always_comb begin
        logic found;
        int   idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        o_grant = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(i_last) + i) % N;
            if (!found && i_req[idx]) begin
                o_grant[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/decode_job_sched.sv
// Serialises decoder jobs: round-robin grant, one job at a time, watchdog abort,
// and a write-port mux that follows the grant owner through LAUNCH/RUN/DRAIN.
module decode_job_sched
    import abr_params_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                          clk,
    input  logic                                          reset_n,
    input  logic                                          zeroize,
    input  logic [NUM_REQ-1:0]                            job_req_i,
    input  logic [NUM_REQ-1:0][ABR_MEM_ADDR_WIDTH-1:0]    job_base_addr_i,
    output logic [NUM_REQ-1:0]                            dec_enable_o,
    output logic [ABR_MEM_ADDR_WIDTH-1:0]                 dec_dest_base_addr_o,
    input  logic [NUM_REQ-1:0]                            dec_done_i,
    output logic [NUM_REQ-1:0]                            dec_abort_o,
    input  mem_if_t [NUM_REQ-1:0]                         dec_mem_a_wr_req_i,
    input  mem_if_t [NUM_REQ-1:0]                         dec_mem_b_wr_req_i,
    input  mem_data_t [NUM_REQ-1:0]                       dec_mem_a_wr_data_i,
    input  mem_data_t [NUM_REQ-1:0]                       dec_mem_b_wr_data_i,
    output mem_if_t                                       mem_a_wr_req_o,
    output mem_if_t                                       mem_b_wr_req_o,
    output mem_data_t                                     mem_a_wr_data_o,
    output mem_data_t                                     mem_b_wr_data_o,
    output logic [NUM_REQ-1:0]                            job_done_o,
    output logic                                          busy_o,
    output logic [2:0]                                    err_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_RUN, S_DRAIN} state_e;

    state_e                                   r_state, w_state_next;
    logic [NUM_REQ-1:0]                       r_pending;
    logic [NUM_REQ-1:0][ABR_MEM_ADDR_WIDTH-1:0] r_base;
    logic [ABR_MEM_ADDR_WIDTH-1:0]            r_dest;
    logic [IDX_W-1:0]                         r_last, r_grant_idx, w_pick_idx;
    logic [CNT_W-1:0]                         r_cnt, w_cnt_inc;
    logic [2:0]                               r_err;
    logic [NUM_REQ-1:0]                       w_pick, w_grant_oh, w_accept, w_dup, w_spurious, w_clr;
    logic                                     w_held, w_live, w_launch, w_owner_done, w_timeout;

    abr_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .i_req   (r_pending),
        .i_last  (r_last),
        .o_grant (w_pick)
    );

    assign w_held       = (r_state != S_IDLE);
    assign w_live       = w_held && !zeroize;
    assign w_launch     = (r_state == S_IDLE) && (|r_pending);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_owner_done = (r_state == S_RUN) && (|(dec_done_i & w_grant_oh));
    assign w_timeout    = (r_state == S_RUN) && !w_owner_done && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign w_clr        = w_launch ? w_pick : '0;

    always_comb begin
        w_pick_idx = '0;
        w_grant_oh = '0;
        w_accept   = '0;
        w_dup      = '0;
        w_spurious = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) w_pick_idx = IDX_W'(i);
            w_grant_oh[i] = (r_grant_idx == IDX_W'(i));
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            // The owner may queue its next job in the very cycle it reports done.
            w_accept[r]   = job_req_i[r] && !r_pending[r]
                            && !(w_held && w_grant_oh[r] && !w_owner_done);
            w_dup[r]      = job_req_i[r] && !w_accept[r];
            w_spurious[r] = dec_done_i[r] && !((r_state == S_RUN) && w_grant_oh[r]);
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_launch) w_state_next = S_LAUNCH;
            S_LAUNCH: w_state_next = S_RUN;
            S_RUN: begin
                if (w_owner_done)   w_state_next = S_DRAIN;
                else if (w_timeout) w_state_next = S_IDLE;
            end
            S_DRAIN:  w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_base      <= '0;
            r_dest      <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_grant_idx <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
        end else if (zeroize) begin
            r_state     <= S_IDLE;
            r_pending   <= '0;
            r_base      <= '0;
            r_dest      <= '0;
            r_last      <= IDX_W'(NUM_REQ - 1);
            r_grant_idx <= '0;
            r_cnt       <= '0;
            r_err       <= '0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= (r_pending | w_accept) & ~w_clr;
            for (int r = 0; r < NUM_REQ; r++) begin
                if (w_accept[r]) r_base[r] <= job_base_addr_i[r];
            end
            if (w_launch) begin
                r_grant_idx <= w_pick_idx;
                r_last      <= w_pick_idx;
                r_dest      <= r_base[w_pick_idx];
            end
            if (r_state == S_LAUNCH)   r_cnt <= '0;
            else if (r_state == S_RUN) r_cnt <= w_cnt_inc;
            r_err <= r_err | {w_timeout, |w_spurious, |w_dup};
        end
    end

    assign dec_enable_o         = (w_live && r_state == S_LAUNCH) ? w_grant_oh : '0;
    assign dec_abort_o          = (w_timeout && !zeroize) ? w_grant_oh : '0;
    assign job_done_o           = (w_live && r_state == S_DRAIN) ? w_grant_oh : '0;
    assign dec_dest_base_addr_o = r_dest;
    assign busy_o               = w_live;
    assign err_o                = r_err;

    // Write ports follow the grant owner combinationally; everyone else is dropped.
    always_comb begin
        mem_a_wr_req_o.rd_wr_en = RW_IDLE;
        mem_a_wr_req_o.addr     = '0;
        mem_b_wr_req_o.rd_wr_en = RW_IDLE;
        mem_b_wr_req_o.addr     = '0;
        mem_a_wr_data_o         = '0;
        mem_b_wr_data_o         = '0;
        if (w_live) begin
            mem_a_wr_req_o  = dec_mem_a_wr_req_i[r_grant_idx];
            mem_b_wr_req_o  = dec_mem_b_wr_req_i[r_grant_idx];
            mem_a_wr_data_o = dec_mem_a_wr_data_i[r_grant_idx];
            mem_b_wr_data_o = dec_mem_b_wr_data_i[r_grant_idx];
        end
    end

endmodule

// File: tb/tb_decode_job_sched.sv
// Directed bench for decode_job_sched: single job, round-robin order, write
// muxing, watchdog abort, duplicate/spurious errors, done+request overlap, zeroize.
module tb_decode_job_sched;
    import abr_params_pkg::*;

    localparam int NR = 2;
    localparam int TO = 16;
    localparam int AW = ABR_MEM_ADDR_WIDTH;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   zeroize;
    logic [NR-1:0]          job_req;
    logic [NR-1:0][AW-1:0]  base;
    logic [NR-1:0]          dec_en, done_in, abort, job_done;
    logic [AW-1:0]          dest;
    mem_if_t [NR-1:0]       a_req_in, b_req_in;
    mem_data_t [NR-1:0]     a_dat_in, b_dat_in;
    mem_if_t                a_req_out, b_req_out;
    mem_data_t              a_dat_out, b_dat_out;
    logic                   busy;
    logic [2:0]             err;

    int n_vec = 0;
    int n_err = 0;

    decode_job_sched #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .zeroize              (zeroize),
        .job_req_i            (job_req),
        .job_base_addr_i      (base),
        .dec_enable_o         (dec_en),
        .dec_dest_base_addr_o (dest),
        .dec_done_i           (done_in),
        .dec_abort_o          (abort),
        .dec_mem_a_wr_req_i   (a_req_in),
        .dec_mem_b_wr_req_i   (b_req_in),
        .dec_mem_a_wr_data_i  (a_dat_in),
        .dec_mem_b_wr_data_i  (b_dat_in),
        .mem_a_wr_req_o       (a_req_out),
        .mem_b_wr_req_o       (b_req_out),
        .mem_a_wr_data_o      (a_dat_out),
        .mem_b_wr_data_o      (b_dat_out),
        .job_done_o           (job_done),
        .busy_o               (busy),
        .err_o                (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        zeroize  = 1'b0;
        job_req  = '0;
        base     = '0;
        done_in  = '0;
        a_req_in = '0;
        b_req_in = '0;
        a_dat_in = '0;
        b_dat_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        #7;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        idle_inputs();
        reset_n = 1'b0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 3'b000);
        check("rst_en", dec_en, 2'b00);
        check("rst_done", job_done, 2'b00);
        check("rst_mem_a", a_req_out, 17'h0);
        reset_n = 1'b1;
        tick();

        // Single job on requester 0, plus requester 1 trying to write meanwhile
        job_req = 2'b01; base[0] = 15'h040;
        tick();
        job_req = '0;
        check("b_idle_en", dec_en, 2'b00);
        tick();
        check("b_launch_en", dec_en, 2'b01);
        check("b_dest", dest, 15'h040);
        check("b_busy", busy, 1'b1);
        tick();
        check("b_run_en", dec_en, 2'b00);
        a_req_in[0] = '{rd_wr_en: RW_WRITE, addr: 15'h123};
        a_dat_in[0] = 96'h000001_000002_000003_000004;
        a_req_in[1] = '{rd_wr_en: RW_WRITE, addr: 15'h010};
        a_dat_in[1] = 96'hffffff_ffffff_ffffff_ffffff;
        b_req_in[1] = '{rd_wr_en: RW_WRITE, addr: 15'h010};
        #1;
        check("b_mem_a_req", a_req_out, {RW_WRITE, 15'h123});
        check("b_mem_a_dat", a_dat_out, 96'h000001_000002_000003_000004);
        check("b_mem_b_req", b_req_out, 17'h0);
        done_in = 2'b01;
        tick();
        done_in = '0;
        check("b_drain_done", job_done, 2'b01);
        check("b_drain_busy", busy, 1'b1);
        tick();
        check("b_idle_busy", busy, 1'b0);
        check("b_idle_done", job_done, 2'b00);
        check("b_idle_mem_a", a_req_out, 17'h0);
        check("b_err", err, 3'b000);

        // Round-robin: 2'b11 twice after reset
        do_reset();
        job_req = 2'b11; base[0] = 15'h100; base[1] = 15'h200;
        tick();
        job_req = '0;
        tick();
        check("c_first_en", dec_en, 2'b01);
        check("c_first_dest", dest, 15'h100);
        tick();
        done_in = 2'b01;
        tick();
        done_in = '0;
        tick();
        tick();
        check("c_second_en", dec_en, 2'b10);
        check("c_second_dest", dest, 15'h200);
        tick();
        done_in = 2'b10;
        tick();
        done_in = '0;
        check("c_second_done", job_done, 2'b10);
        tick();
        job_req = 2'b11; base[0] = 15'h0AA; base[1] = 15'h0BB;
        tick();
        job_req = '0;
        tick();
        check("c_third_en", dec_en, 2'b01);
        check("c_third_dest", dest, 15'h0AA);
        check("c_err", err, 3'b000);

        // Watchdog: requester 0 never finishes, requester 1 waits
        do_reset();
        job_req = 2'b01; base[0] = 15'h007;
        tick();
        job_req = '0;
        tick();
        tick();
        job_req = 2'b10; base[1] = 15'h022;
        tick();
        job_req = '0;
        repeat (13) tick();
        check("d_run15_abort", abort, 2'b00);
        check("d_run15_busy", busy, 1'b1);
        tick();
        check("d_run16_abort", abort, 2'b01);
        tick();
        check("d_to_err", err, 3'b100);
        check("d_to_done", job_done, 2'b00);
        check("d_to_abort", abort, 2'b00);
        check("d_to_busy", busy, 1'b0);
        tick();
        check("d_next_en", dec_en, 2'b10);
        check("d_next_dest", dest, 15'h022);

        // Duplicate request and stray done
        do_reset();
        job_req = 2'b01; base[0] = 15'h011;
        tick();
        base[0] = 15'h033;
        tick();
        job_req = '0;
        check("e_dup_err", err, 3'b001);
        check("e_dup_dest", dest, 15'h011);
        tick();
        done_in = 2'b10;
        tick();
        done_in = '0;
        check("e_spur_err", err, 3'b011);
        check("e_spur_done", job_done, 2'b00);
        done_in = 2'b01;
        tick();
        done_in = '0;
        check("e_done", job_done, 2'b01);
        tick();
        tick();
        check("e_one_job_busy", busy, 1'b0);
        check("e_one_job_en", dec_en, 2'b00);

        // Request overlapping the owner's done, then zeroize mid-run
        do_reset();
        job_req = 2'b01; base[0] = 15'h001;
        tick();
        job_req = '0;
        tick();
        tick();
        done_in = 2'b01; job_req = 2'b11; base[0] = 15'h005; base[1] = 15'h02A;
        tick();
        done_in = '0; job_req = '0;
        check("f_overlap_err", err, 3'b000);
        check("f_overlap_done", job_done, 2'b01);
        tick();
        tick();
        check("f_next_en", dec_en, 2'b10);
        check("f_next_dest", dest, 15'h02A);
        tick();
        job_req = 2'b10;
        a_req_in[1] = '{rd_wr_en: RW_WRITE, addr: 15'h3C0};
        tick();
        job_req = '0;
        check("f_owner_dup_err", err, 3'b001);
        check("f_owner_mem_a", a_req_out, {RW_WRITE, 15'h3C0});
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        #1;
        check("f_zero_busy", busy, 1'b0);
        check("f_zero_err", err, 3'b000);
        check("f_zero_done", job_done, 2'b00);
        check("f_zero_en", dec_en, 2'b00);
        check("f_zero_mem_a", a_req_out, 17'h0);
        check("f_zero_dest", dest, 15'h000);
        tick();
        check("f_after_busy", busy, 1'b0);
        check("f_after_done", job_done, 2'b00);
        check("f_after_en", dec_en, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
